// File: rtl/keyboard_key_tracker.sv
// rtl/keyboard_key_tracker.sv - make/break key-state tracker with typematic filtering and break timeout
module keyboard_key_tracker #(
    parameter int                           NUM_KEYS       = 4,
    parameter int                           CODE_W         = 16,
    parameter logic [NUM_KEYS*CODE_W-1:0]   KEY_CODES      = {16'h3541, 16'h3239, 16'h3143, 16'h3233},
    parameter logic [CODE_W-1:0]            RELEASE_CODE   = 16'h4630,
    parameter int                           TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   code,
    input  logic                code_valid,
    input  logic                flush,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_released,
    output logic                unknown_code,
    output logic                break_pending
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {MAKE, BREAK} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_KEYS-1:0] held_d, pressed_d, released_d;
    logic                unknown_d;
    logic [NUM_KEYS-1:0] match;
    logic                is_release;

    // Duplicate key codes simply light several match bits, so all copies move together.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_match
        assign match[i] = (code == KEY_CODES[i*CODE_W +: CODE_W]);
    end

    assign is_release = (code == RELEASE_CODE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        held_d     = key_held;
        pressed_d  = '0;
        released_d = '0;
        unknown_d  = 1'b0;
        if (flush) begin
            held_d  = '0;
            state_d = MAKE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                MAKE: begin
                    if (code_valid) begin
                        if (is_release) begin
                            state_d = BREAK;
                            cnt_d   = CNT_LOAD;
                        end else if (|match) begin
                            pressed_d = match & ~key_held;
                            held_d    = key_held | match;
                        end else begin
                            unknown_d = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    // A word arriving on the expiry cycle is still treated as part of the break.
                    if (code_valid) begin
                        if (is_release) begin
                            cnt_d = CNT_LOAD;
                        end else begin
                            state_d = MAKE;
                            cnt_d   = '0;
                            if (|match) begin
                                released_d = match & key_held;
                                held_d     = key_held & ~match;
                            end else begin
                                unknown_d = 1'b1;
                            end
                        end
                    end else if (cnt_q == '0) begin
                        state_d = MAKE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = MAKE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MAKE;
            cnt_q        <= '0;
            key_held     <= '0;
            key_pressed  <= '0;
            key_released <= '0;
            unknown_code <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_held     <= held_d;
            key_pressed  <= pressed_d;
            key_released <= released_d;
            unknown_code <= unknown_d;
        end
    end

    assign break_pending = (state_q == BREAK);

endmodule

// File: tb/tb_keyboard_key_tracker.sv
// tb/tb_keyboard_key_tracker.sv - vector-table and scoreboard bench for keyboard_key_tracker
module tb_keyboard_key_tracker;

    localparam logic [15:0] K_D  = 16'h3233;
    localparam logic [15:0] K_A  = 16'h3143;
    localparam logic [15:0] K_SP = 16'h3239;
    localparam logic [15:0] K_EN = 16'h3541;
    localparam logic [15:0] K_RL = 16'h4630;
    localparam logic [15:0] K_UK = 16'h1234;

    logic        clk = 1'b0;
    logic        rst, flush, code_valid;
    logic [15:0] code;
    logic [3:0]  key_held, key_pressed, key_released;
    logic        unknown_code, break_pending;

    always #5 clk = ~clk;

    keyboard_key_tracker #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .code         (code),
        .code_valid   (code_valid),
        .flush        (flush),
        .key_held     (key_held),
        .key_pressed  (key_pressed),
        .key_released (key_released),
        .unknown_code (unknown_code),
        .break_pending(break_pending)
    );

    typedef struct packed {
        logic        r;
        logic        f;
        logic        v;
        logic [15:0] c;
        logic [13:0] e;
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [13:0] sb[$];
    vec_t        tbl[$];

    function automatic logic [13:0] ex(input logic [3:0] h, input logic [3:0] p,
                                       input logic [3:0] rl, input logic u, input logic bp);
        return {h, p, rl, u, bp};
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic v,
                                input logic [15:0] c, input logic [13:0] e);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.c = c; t.e = e;
        return t;
    endfunction

    task automatic apply(input vec_t t, input int id);
        logic [13:0] got, want;
        rst = t.r; flush = t.f; code_valid = t.v; code = t.c;
        sb.push_back(t.e);
        @(posedge clk);
        #1;
        want = sb.pop_front();
        got  = {key_held, key_pressed, key_released, unknown_code, break_pending};
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL vec%0d: got held=%b pr=%b rel=%b unk=%b bp=%b, expected held=%b pr=%b rel=%b unk=%b bp=%b",
                      id, got[13:10], got[9:6], got[5:2], got[1], got[0],
                      want[13:10], want[9:6], want[5:2], want[1], want[0]);
    endtask

    task automatic measure_pending(input string name);
        int cnt;
        cnt = 0;
        while (break_pending === 1'b1 && cnt < 20) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (cnt == 4) n_pass++;
        else $display("FAIL %s: break_pending high %0d cycles, expected 4", name, cnt);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; code_valid = 1'b0; code = '0;

        tbl.push_back(mk(1, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0001, 4'b0001, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0001, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0001, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0001, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0001, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0000, 4'b0000, 4'b0001, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_A,  ex(4'b0010, 4'b0010, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_SP, ex(4'b0110, 4'b0100, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0110, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_A,  ex(4'b0100, 4'b0000, 4'b0010, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0100, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0101, 4'b0001, 4'b0000, 0, 0)));
        // timeout: pending for exactly four sampled cycles, then D is a repeat
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0101, 4'b0000, 4'b0000, 0, 0)));
        // unknown words in BREAK and in MAKE
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_UK, ex(4'b0101, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(mk(0, 0, 1, K_UK, ex(4'b0101, 4'b0000, 4'b0000, 1, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 0)));
        // repeated break prefix stays in BREAK
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0100, 4'b0000, 4'b0001, 0, 0)));
        // code on the expiry cycle wins over timeout
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0101, 4'b0001, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0101, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0100, 4'b0000, 4'b0001, 0, 0)));
        // flush with D and ENTER held beats a simultaneous A press
        tbl.push_back(mk(0, 0, 1, K_EN, ex(4'b1100, 4'b1000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b1101, 4'b0001, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 1, 1, K_A,  ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        // flush inside BREAK: no release pulse
        tbl.push_back(mk(0, 0, 1, K_D,  ex(4'b0001, 4'b0001, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0001, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(0, 1, 1, K_D,  ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        // reset in the middle of BREAK
        tbl.push_back(mk(0, 0, 1, K_A,  ex(4'b0010, 4'b0010, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 1, K_RL, ex(4'b0010, 4'b0000, 4'b0000, 0, 1)));
        tbl.push_back(mk(1, 0, 1, K_A,  ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));
        tbl.push_back(mk(0, 0, 0, '0,   ex(4'b0000, 4'b0000, 4'b0000, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

        rst = 1'b0; flush = 1'b0;
        code_valid = 1'b1; code = K_RL;
        @(posedge clk); #1;
        code_valid = 1'b0; code = '0;
        measure_pending("timeout_width");

        code_valid = 1'b1; code = K_RL;
        @(posedge clk); #1;
        code_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        code_valid = 1'b1; code = K_RL;
        @(posedge clk); #1;
        code_valid = 1'b0; code = '0;
        measure_pending("timeout_reload");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
